// File: rtl/ws_systolic_array_if.sv
// Handshake and result bus of the weight-stationary systolic engine.
// The master drives weight rows and activations; the slave (the engine) returns results and status.
interface ws_systolic_array_if #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16
) ();
    logic                  wload_valid;
    logic                  wload_ready;
    logic [N*DATA_W-1:0]   wload_data;
    logic                  act_valid;
    logic                  act_ready;
    logic [N*DATA_W-1:0]   act_data;
    logic                  out_valid;
    logic [N*OUT_W-1:0]    out_data;
    logic                  weights_loaded;
    logic                  busy;

    modport master (
        output wload_valid, wload_data, act_valid, act_data,
        input  wload_ready, act_ready, out_valid, out_data, weights_loaded, busy
    );

    modport slave (
        input  wload_valid, wload_data, act_valid, act_data,
        output wload_ready, act_ready, out_valid, out_data, weights_loaded, busy
    );
endinterface

// File: rtl/ws_systolic_array.sv
// NxN weight-stationary systolic matrix-vector engine: y[j] = sum_i x[i]*W[i][j].
// Row-wise weight loading, skewed activation entry, deskewed outputs, fixed latency 2*N+1.
module ws_systolic_array #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 16,
    parameter int SAT    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    ws_systolic_array_if.slave   bus
);

    localparam int LAT = 2 * N + 1;
    localparam int CW  = $clog2(LAT + 1);
    localparam int RW  = $clog2(N);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                    state_q, state_d;
    logic [RW-1:0]             row_q, row_d, wr_row;
    logic [CW-1:0]             inflight_q;
    logic                      wready, aready, wfire, afire;
    logic [LAT-1:0]            vld_q;
    logic                      out_valid_q;
    logic [N*OUT_W-1:0]        out_data_q;

    logic signed [DATA_W-1:0]  w_q  [N][N];
    logic signed [DATA_W-1:0]  sk_q [N][N];
    logic signed [DATA_W-1:0]  a_q  [N][N];
    logic signed [ACC_W-1:0]   p_q  [N][N];
    logic signed [ACC_W-1:0]   ds_q [N][N];

    function automatic logic [OUT_W-1:0] clip(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] hi, lo;
        hi = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        lo = ~hi;
        if (SAT != 0 && v > hi)      return hi[OUT_W-1:0];
        else if (SAT != 0 && v < lo) return lo[OUT_W-1:0];
        else                         return v[OUT_W-1:0];
    endfunction

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        wready  = 1'b1;
        aready  = 1'b0;
        wr_row  = '0;
        case (state_q)
            LOAD:    wr_row = row_q;
            RUN: begin
                aready = 1'b1;
                // Activations win; weights may only change with an empty pipe.
                wready = (inflight_q == '0) && !bus.act_valid;
            end
            default: ;
        endcase
        wfire = bus.wload_valid && wready;
        afire = bus.act_valid && aready;
        if (wfire) begin
            if (state_q == LOAD) begin
                if (row_q == RW'(N - 1)) begin
                    state_d = RUN;
                    row_d   = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                state_d = LOAD;
                row_d   = RW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            inflight_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            case ({afire, out_valid_q})
                2'b10:   inflight_q <= inflight_q + CW'(1);
                2'b01:   inflight_q <= inflight_q - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: weight, skew and deskew storage is reset too, because a reset must leave no stale data in the array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    w_q[i][k]  <= '0;
                    sk_q[i][k] <= '0;
                    ds_q[i][k] <= '0;
                end
            end
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wfire) w_q[wr_row][i] <= bus.wload_data[i*DATA_W +: DATA_W];
                sk_q[i][0] <= afire ? bus.act_data[i*DATA_W +: DATA_W] : '0;
                ds_q[i][0] <= p_q[N-1][i];
                for (int k = 1; k < N; k++) begin
                    sk_q[i][k] <= sk_q[i][k-1];
                    ds_q[i][k] <= ds_q[i][k-1];
                end
            end
            vld_q       <= {vld_q[LAT-2:0], afire};
            out_valid_q <= vld_q[LAT-1];
            // Column j leaves the array j cycles late; a deskew of N-j stages aligns all lanes.
            if (vld_q[LAT-1]) begin
                for (int j = 0; j < N; j++) out_data_q[j*OUT_W +: OUT_W] <= clip(ds_q[j][N-1-j]);
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic signed [DATA_W-1:0]   a_in, a_r;
            logic signed [ACC_W-1:0]    p_in, p_r;
            logic signed [2*DATA_W-1:0] prod;

            if (gj == 0) begin : g_edge
                assign a_in = sk_q[gi][gi];
            end else begin : g_inner
                assign a_in = a_q[gi][gj-1];
            end
            if (gi == 0) begin : g_top
                assign p_in = '0;
            end else begin : g_below
                assign p_in = p_q[gi-1][gj];
            end

            assign prod = (2*DATA_W)'(a_in) * (2*DATA_W)'(w_q[gi][gj]);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_r <= '0;
                    p_r <= '0;
                end else begin
                    a_r <= a_in;
                    p_r <= p_in + ACC_W'(prod);
                end
            end

            assign a_q[gi][gj] = a_r;
            assign p_q[gi][gj] = p_r;
        end
    end

    assign bus.wload_ready    = wready;
    assign bus.act_ready      = aready;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = out_data_q;
    assign bus.weights_loaded = (state_q == RUN);
    assign bus.busy           = (state_q == LOAD) || (inflight_q != '0);

endmodule
